// File: rtl/batalla_pkg.sv
// Shared board geometry, controller state encoding and cell addressing for the
// battleship ship-placement logic.
package batalla_pkg;

    localparam int FILAS     = 5;
    localparam int COLS      = 5;
    localparam int CELDAS    = FILAS * COLS;
    localparam int MAX_LARGO = (FILAS > COLS) ? FILAS : COLS;

    typedef enum logic [2:0] {
        IDLE,
        ESPERA,
        VALIDA,
        ESCRIBE,
        FIN
    } estado_t;

    // Cell covered by segment i of a ship anchored at origen (top/left end).
    function automatic logic [4:0] celda_idx(input logic [4:0] origen,
                                             input logic [2:0] i,
                                             input logic       vertical);
        logic [4:0] paso;
        paso = vertical ? 5'(COLS) : 5'd1;
        return origen + ({2'b00, i} * paso);
    endfunction

endpackage

// File: rtl/colocador_barcos_validador.sv
// Combinational placement check: ship must stay on the board without wrapping
// and must not touch any committed cell.
module validador_colocacion #(
    parameter int FILAS = 5,
    parameter int COLS  = 5
) (
    input  logic [4:0]             origen,
    input  logic                   vertical,
    input  logic [2:0]             largo,
    input  logic [FILAS*COLS-1:0]  ocupado,
    output logic                   valido
);
    import batalla_pkg::*;

    localparam int NCELDAS = FILAS * COLS;

    logic [3:0] fila;
    logic [3:0] col;
    logic [3:0] fin_fila;
    logic [3:0] fin_col;
    logic       fuera;
    logic       solapa;
    logic [4:0] celda;

    always_comb begin
        fila     = 4'(origen / 5'(COLS));
        col      = 4'(origen % 5'(COLS));
        fin_fila = fila + {1'b0, largo};
        fin_col  = col + {1'b0, largo};
        fuera    = (origen >= 5'(NCELDAS)) ||
                   (vertical ? (fin_fila > 4'(FILAS)) : (fin_col > 4'(COLS)));

        // Overlap is only meaningful once the ship is known to fit on the board.
        solapa = 1'b0;
        celda  = '0;
        for (int j = 0; j < MAX_LARGO; j++) begin
            celda = celda_idx(origen, 3'(j), vertical);
            if (!fuera && (3'(j) < largo) && ocupado[celda])
                solapa = 1'b1;
        end

        valido = !fuera && !solapa;
    end

endmodule

// File: rtl/colocador_barcos.sv
// Placement sequencer: takes ships 1..NUM_BARCOS in order, validates each
// origin/orientation and streams accepted ships one cell per cycle.
module colocador_barcos #(
    parameter int FILAS      = 5,
    parameter int COLS       = 5,
    parameter int NUM_BARCOS = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   confirm,
    input  logic [4:0]             origen,
    input  logic                   vertical,
    output logic                   enable,
    output logic [2:0]             tipo,
    output logic [4:0]             casilla,
    output logic [FILAS*COLS-1:0]  ocupado,
    output logic [2:0]             barco_actual,
    output logic                   busy,
    output logic                   error,
    output logic                   listo
);
    import batalla_pkg::*;

    estado_t    estado;
    logic [2:0] k;
    logic [2:0] i;
    logic [4:0] origen_lat;
    logic       vertical_lat;
    logic       valido;
    logic [4:0] celda_sig;

    validador_colocacion #(
        .FILAS (FILAS),
        .COLS  (COLS)
    ) u_validador (
        .origen   (origen_lat),
        .vertical (vertical_lat),
        .largo    (k),
        .ocupado  (ocupado),
        .valido   (valido)
    );

    assign barco_actual = k;

    always_comb celda_sig = celda_idx(origen_lat, i, vertical_lat);

    // Latched choice is data only; it is rewritten on every accepted confirm.
    always_ff @(posedge clk) begin
        if (estado == ESPERA && confirm) begin
            origen_lat   <= origen;
            vertical_lat <= vertical;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado  <= IDLE;
            k       <= '0;
            i       <= '0;
            enable  <= 1'b0;
            tipo    <= '0;
            casilla <= '0;
            ocupado <= '0;
            busy    <= 1'b0;
            error   <= 1'b0;
            listo   <= 1'b0;
        end else begin
            enable  <= 1'b0;
            tipo    <= '0;
            casilla <= '0;
            error   <= 1'b0;

            case (estado)
                IDLE, FIN: begin
                    if (start) begin
                        estado  <= ESPERA;
                        k       <= 3'd1;
                        ocupado <= '0;
                        listo   <= 1'b0;
                    end
                end
                ESPERA: begin
                    if (confirm) begin
                        estado <= VALIDA;
                        i      <= '0;
                        busy   <= 1'b1;
                    end
                end
                VALIDA: begin
                    if (valido) begin
                        estado             <= ESCRIBE;
                        enable             <= 1'b1;
                        tipo               <= k;
                        casilla            <= celda_sig;
                        ocupado[celda_sig] <= 1'b1;
                        i                  <= 3'd1;
                    end else begin
                        estado <= ESPERA;
                        error  <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                ESCRIBE: begin
                    // i counts cells already on the bus; the final one went out last edge.
                    if (i == k) begin
                        busy <= 1'b0;
                        if (k == 3'(NUM_BARCOS)) begin
                            estado <= FIN;
                            listo  <= 1'b1;
                        end else begin
                            estado <= ESPERA;
                            k      <= k + 3'd1;
                        end
                    end else begin
                        enable             <= 1'b1;
                        tipo               <= k;
                        casilla            <= celda_sig;
                        ocupado[celda_sig] <= 1'b1;
                        i                  <= i + 3'd1;
                    end
                end
                default: estado <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_colocador_barcos.sv
// Directed bench for colocador_barcos: walks a full placement round with
// rejected and accepted ships, FIN behaviour, restart and reset mid-write.
module tb_colocador_barcos;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        confirm;
    logic [4:0]  origen;
    logic        vertical;
    logic        enable;
    logic [2:0]  tipo;
    logic [4:0]  casilla;
    logic [24:0] ocupado;
    logic [2:0]  barco_actual;
    logic        busy;
    logic        error;
    logic        listo;

    int n_vec = 0;
    int n_err = 0;

    colocador_barcos dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .confirm      (confirm),
        .origen       (origen),
        .vertical     (vertical),
        .enable       (enable),
        .tipo         (tipo),
        .casilla      (casilla),
        .ocupado      (ocupado),
        .barco_actual (barco_actual),
        .busy         (busy),
        .error        (error),
        .listo        (listo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_enable"}, enable, 0);
        chk({tag, "_tipo"}, tipo, 0);
        chk({tag, "_casilla"}, casilla, 0);
        chk({tag, "_ocupado"}, ocupado, 0);
        chk({tag, "_barco"}, barco_actual, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_listo"}, listo, 0);
    endtask

    // Confirm a placement for ship k; inputs are scrambled right after the
    // confirm edge so the DUT must be using its latched copy.
    task automatic place(input logic [4:0] org, input logic vert, input bit acepta,
                         input int k, input logic [24:0] ocup_fin);
        origen = org; vertical = vert; confirm = 1'b1;
        tick();
        confirm = 1'b0; origen = 5'd31; vertical = ~vert;
        chk("busy_valida", busy, 1);
        chk("enable_valida", enable, 0);
        tick();
        if (!acepta) begin
            chk("error_pulse", error, 1);
            chk("enable_rechazo", enable, 0);
            chk("barco_rechazo", barco_actual, k);
            chk("busy_rechazo", busy, 0);
            tick();
            chk("error_un_ciclo", error, 0);
            chk("ocupado_rechazo", ocupado, ocup_fin);
        end else begin
            for (int j = 0; j < k; j++) begin
                int c;
                c = org + j * (vert ? 5 : 1);
                chk("enable_w", enable, 1);
                chk("tipo_w", tipo, k);
                chk("casilla_w", casilla, c);
                chk("ocupado_w", ocupado[c], 1);
                chk("busy_w", busy, 1);
                chk("error_w", error, 0);
                tick();
            end
            chk("enable_tras", enable, 0);
            chk("busy_tras", busy, 0);
            chk("ocupado_tras", ocupado, ocup_fin);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; confirm = 1'b0; origen = '0; vertical = 1'b0;
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;

        // confirm in IDLE does nothing
        confirm = 1'b1;
        tick();
        confirm = 1'b0;
        chk("idle_confirm_barco", barco_actual, 0);
        chk("idle_confirm_busy", busy, 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_barco", barco_actual, 1);
        chk("start_ocupado", ocupado, 0);

        place(5'd0, 1'b0, 1'b1, 1, 25'h0000001);
        chk("barco_tras_1", barco_actual, 2);

        // start while waiting for a ship is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("espera_start_barco", barco_actual, 2);
        chk("espera_start_ocupado", ocupado, 25'h0000001);

        place(5'd4, 1'b0, 1'b0, 2, 25'h0000001);
        place(5'd5, 1'b1, 1'b1, 2, 25'h0000421);
        chk("barco_tras_2", barco_actual, 3);

        place(5'd9,  1'b0, 1'b0, 3, 25'h0000421);
        place(5'd0,  1'b1, 1'b0, 3, 25'h0000421);
        place(5'd30, 1'b0, 1'b0, 3, 25'h0000421);
        place(5'd15, 1'b1, 1'b0, 3, 25'h0000421);
        place(5'd15, 1'b0, 1'b1, 3, 25'h0038421);
        chk("barco_tras_3", barco_actual, 4);

        place(5'd14, 1'b1, 1'b0, 4, 25'h0038421);
        place(5'd9,  1'b1, 1'b1, 4, 25'h10BC621);
        chk("barco_tras_4", barco_actual, 5);

        place(5'd8, 1'b1, 1'b0, 5, 25'h10BC621);
        place(5'd3, 1'b1, 1'b1, 5, 25'h18FE729);
        chk("fin_listo", listo, 1);
        chk("fin_barco", barco_actual, 5);

        // confirm in FIN has no effect
        origen = 5'd2; vertical = 1'b0; confirm = 1'b1;
        tick();
        confirm = 1'b0;
        tick();
        chk("fin_confirm_enable", enable, 0);
        chk("fin_confirm_busy", busy, 0);
        chk("fin_confirm_error", error, 0);
        chk("fin_confirm_listo", listo, 1);
        chk("fin_confirm_ocupado", ocupado, 25'h18FE729);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_ocupado", ocupado, 0);
        chk("restart_barco", barco_actual, 1);
        chk("restart_listo", listo, 0);

        place(5'd0,  1'b0, 1'b1, 1, 25'h0000001);
        place(5'd5,  1'b1, 1'b1, 2, 25'h0000421);
        place(5'd15, 1'b0, 1'b1, 3, 25'h0038421);

        // reset during the third write of ship 4
        origen = 5'd9; vertical = 1'b1; confirm = 1'b1;
        tick();
        confirm = 1'b0;
        tick();
        chk("rst_w0_casilla", casilla, 9);
        tick();
        chk("rst_w1_casilla", casilla, 14);
        tick();
        chk("rst_w2_casilla", casilla, 19);
        chk("rst_w2_enable", enable, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("rst_escribe");

        // back in IDLE: confirm ignored, start opens ship 1
        confirm = 1'b1;
        tick();
        confirm = 1'b0;
        chk("post_rst_barco", barco_actual, 0);
        chk("post_rst_busy", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("post_rst_start", barco_actual, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
